// File: rtl/ssrv_dmem_delay_shim.sv
`default_nettype none
// ============================================================================
// Module   : ssrv_dmem_delay_shim
// Brief    : Core-to-model DMEM shim that inserts LFSR-driven wait states and
//            returns RDY_ER for illegal accesses and memory timeouts.
// Revision : 1.0 - initial release
// ============================================================================

package ssrv_dmem_shim_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module ssrv_dmem_delay_shim
    import ssrv_dmem_shim_pkg::*;
#(
    parameter int          AWIDTH    = 32,
    parameter int          DWIDTH    = 32,
    parameter int          MIN_DELAY = 0,
    parameter int          DELAY_W   = 3,
    parameter int          RAND_EN   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 core_dmem_req,
    input  type_scr1_mem_cmd_e   core_dmem_cmd,
    input  type_scr1_mem_width_e core_dmem_width,
    input  logic [AWIDTH-1:0]    core_dmem_addr,
    input  logic [DWIDTH-1:0]    core_dmem_wdata,
    output logic                 core_dmem_req_ack,
    output logic [DWIDTH-1:0]    core_dmem_rdata,
    output type_scr1_mem_resp_e  core_dmem_resp,
    output logic                 mem_dmem_req,
    output type_scr1_mem_cmd_e   mem_dmem_cmd,
    output type_scr1_mem_width_e mem_dmem_width,
    output logic [AWIDTH-1:0]    mem_dmem_addr,
    output logic [DWIDTH-1:0]    mem_dmem_wdata,
    input  logic [DWIDTH-1:0]    mem_dmem_rdata,
    input  type_scr1_mem_resp_e  mem_dmem_resp,
    output logic [31:0]          stat_req_cnt,
    output logic [31:0]          stat_err_cnt
);

    localparam int DLY_W = $clog2(MIN_DELAY + (1 << DELAY_W)) + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_MWAIT = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    state_e               state_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_d;
    logic [DLY_W-1:0]     dly_cnt_q;
    logic [DLY_W-1:0]     dly_load_d;
    logic [TO_W-1:0]      to_cnt_q;
    type_scr1_mem_cmd_e   cmd_q;
    type_scr1_mem_width_e width_q;
    logic [AWIDTH-1:0]    addr_q;
    logic [DWIDTH-1:0]    wdata_q;
    logic                 mem_req_q;
    type_scr1_mem_resp_e  resp_q;
    logic [DWIDTH-1:0]    rdata_q;
    logic [31:0]          req_cnt_q;
    logic [31:0]          err_cnt_q;
    logic                 illegal_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        dly_load_d = DLY_W'(MIN_DELAY);
        if (RAND_EN != 0) begin
            dly_load_d = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[DELAY_W-1:0]);
        end
    end

    // Alignment is judged on the captured request, not the live core inputs.
    always_comb begin
        illegal_d = 1'b0;
        case (width_q)
            SCR1_MEM_WIDTH_ERROR: illegal_d = 1'b1;
            SCR1_MEM_WIDTH_HWORD: illegal_d = addr_q[0];
            SCR1_MEM_WIDTH_WORD:  illegal_d = |addr_q[1:0];
            default:              illegal_d = 1'b0;
        endcase
    end

    assign core_dmem_req_ack = (state_q == ST_IDLE) & core_dmem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            dly_cnt_q <= '0;
            to_cnt_q  <= '0;
            cmd_q     <= SCR1_MEM_CMD_RD;
            width_q   <= SCR1_MEM_WIDTH_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            resp_q    <= SCR1_MEM_RESP_NOTRDY;
            rdata_q   <= '0;
            req_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            mem_req_q <= 1'b0;
            resp_q    <= SCR1_MEM_RESP_NOTRDY;
            case (state_q)
                ST_IDLE: begin
                    if (core_dmem_req) begin
                        cmd_q     <= core_dmem_cmd;
                        width_q   <= core_dmem_width;
                        addr_q    <= core_dmem_addr;
                        wdata_q   <= core_dmem_wdata;
                        req_cnt_q <= sat_inc(req_cnt_q);
                        dly_cnt_q <= dly_load_d;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dly_cnt_q == '0) begin
                        if (illegal_d) begin
                            resp_q  <= SCR1_MEM_RESP_RDY_ER;
                            rdata_q <= '0;
                            state_q <= ST_RESP;
                        end else begin
                            mem_req_q <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end else begin
                        dly_cnt_q <= dly_cnt_q - DLY_W'(1);
                    end
                end
                ST_ISSUE: begin
                    to_cnt_q <= TO_W'(TIMEOUT);
                    state_q  <= ST_MWAIT;
                end
                ST_MWAIT: begin
                    if ((mem_dmem_resp == SCR1_MEM_RESP_RDY_OK) ||
                        (mem_dmem_resp == SCR1_MEM_RESP_RDY_ER)) begin
                        resp_q  <= mem_dmem_resp;
                        rdata_q <= (cmd_q == SCR1_MEM_CMD_RD) ? mem_dmem_rdata : '0;
                        state_q <= ST_RESP;
                    end else if (to_cnt_q <= TO_W'(1)) begin
                        // Counter hits zero on this edge: RESP lands TIMEOUT cycles after MWAIT entry.
                        resp_q   <= SCR1_MEM_RESP_RDY_ER;
                        rdata_q  <= '0;
                        to_cnt_q <= '0;
                        state_q  <= ST_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q - TO_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_q == SCR1_MEM_RESP_RDY_ER) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_dmem_rdata = rdata_q;
    assign core_dmem_resp  = resp_q;
    assign mem_dmem_req    = mem_req_q;
    assign mem_dmem_cmd    = cmd_q;
    assign mem_dmem_width  = width_q;
    assign mem_dmem_addr   = addr_q;
    assign mem_dmem_wdata  = wdata_q;
    assign stat_req_cnt    = req_cnt_q;
    assign stat_err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ssrv_dmem_delay_shim.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssrv_dmem_delay_shim
// Brief    : Directed self-checking bench for ssrv_dmem_delay_shim (three configs).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_ssrv_dmem_delay_shim;
    import ssrv_dmem_shim_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]         core_req;
    type_scr1_mem_cmd_e   core_cmd   [N];
    type_scr1_mem_width_e core_width [N];
    logic [31:0]          core_addr  [N];
    logic [31:0]          core_wdata [N];
    logic [31:0]          mem_rdata  [N];
    type_scr1_mem_resp_e  mem_resp   [N];

    logic [N-1:0]        ack;
    logic [N-1:0]        mem_req;
    logic [N-1:0]        mem_cmd;
    logic [N-1:0][1:0]   core_resp;
    logic [N-1:0][1:0]   mem_width;
    logic [N-1:0][31:0]  core_rdata;
    logic [N-1:0][31:0]  mem_addr;
    logic [N-1:0][31:0]  mem_wdata;
    logic [N-1:0][31:0]  st_req;
    logic [N-1:0][31:0]  st_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] g_lfsr;
    logic [7:0]  seen_dly;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) g_lfsr <= 16'hACE1;
        else        g_lfsr <= {1'b0, g_lfsr[15:1]} ^ (g_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Instance 0: fixed zero delay, short timeout; 1: fixed delay 5; 2: random delay.
    ssrv_dmem_delay_shim #(.MIN_DELAY(0), .RAND_EN(0), .TIMEOUT(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .core_dmem_req(core_req[0]), .core_dmem_cmd(core_cmd[0]), .core_dmem_width(core_width[0]),
        .core_dmem_addr(core_addr[0]), .core_dmem_wdata(core_wdata[0]), .core_dmem_req_ack(ack[0]),
        .core_dmem_rdata(core_rdata[0]), .core_dmem_resp(core_resp[0]), .mem_dmem_req(mem_req[0]),
        .mem_dmem_cmd(mem_cmd[0]), .mem_dmem_width(mem_width[0]), .mem_dmem_addr(mem_addr[0]),
        .mem_dmem_wdata(mem_wdata[0]), .mem_dmem_rdata(mem_rdata[0]), .mem_dmem_resp(mem_resp[0]),
        .stat_req_cnt(st_req[0]), .stat_err_cnt(st_err[0]));

    ssrv_dmem_delay_shim #(.MIN_DELAY(5), .RAND_EN(0), .TIMEOUT(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .core_dmem_req(core_req[1]), .core_dmem_cmd(core_cmd[1]), .core_dmem_width(core_width[1]),
        .core_dmem_addr(core_addr[1]), .core_dmem_wdata(core_wdata[1]), .core_dmem_req_ack(ack[1]),
        .core_dmem_rdata(core_rdata[1]), .core_dmem_resp(core_resp[1]), .mem_dmem_req(mem_req[1]),
        .mem_dmem_cmd(mem_cmd[1]), .mem_dmem_width(mem_width[1]), .mem_dmem_addr(mem_addr[1]),
        .mem_dmem_wdata(mem_wdata[1]), .mem_dmem_rdata(mem_rdata[1]), .mem_dmem_resp(mem_resp[1]),
        .stat_req_cnt(st_req[1]), .stat_err_cnt(st_err[1]));

    ssrv_dmem_delay_shim #(.MIN_DELAY(0), .RAND_EN(1), .TIMEOUT(64)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .core_dmem_req(core_req[2]), .core_dmem_cmd(core_cmd[2]), .core_dmem_width(core_width[2]),
        .core_dmem_addr(core_addr[2]), .core_dmem_wdata(core_wdata[2]), .core_dmem_req_ack(ack[2]),
        .core_dmem_rdata(core_rdata[2]), .core_dmem_resp(core_resp[2]), .mem_dmem_req(mem_req[2]),
        .mem_dmem_cmd(mem_cmd[2]), .mem_dmem_width(mem_width[2]), .mem_dmem_addr(mem_addr[2]),
        .mem_dmem_wdata(mem_wdata[2]), .mem_dmem_rdata(mem_rdata[2]), .mem_dmem_resp(mem_resp[2]),
        .stat_req_cnt(st_req[2]), .stat_err_cnt(st_err[2]));

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Cycle 0 is the ack cycle. exp_req_cyc < 0 means no memory request is expected.
    // With rnd set, the golden LFSR delay of the accept cycle is added to both cycle expectations.
    task automatic txn(input int k, input string tag,
                       input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int mlat, input type_scr1_mem_resp_e mr, input logic [31:0] mrd,
                       input int exp_req_cyc, input int exp_resp_cyc,
                       input type_scr1_mem_resp_e exp_r, input logic [31:0] exp_rd,
                       input bit chk_rd, input bit rnd);
        int req_cyc, resp_cyc, n_req, d;
        logic [1:0]  got_r;
        logic [31:0] got_rd;
        req_cyc = -1; resp_cyc = -1; n_req = 0; d = 0; got_r = '0; got_rd = '0;
        @(negedge clk);
        core_req[k] = 1'b1; core_cmd[k] = c; core_width[k] = w;
        core_addr[k] = a; core_wdata[k] = wd;
        if (rnd) d = int'(g_lfsr[2:0]);
        #1 chk_eq({tag, ".ack"}, 32'(ack[k]), 32'd1);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                core_cmd[k]   = (c == SCR1_MEM_CMD_RD) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
                core_width[k] = SCR1_MEM_WIDTH_ERROR;
                core_addr[k]  = ~a;
                core_wdata[k] = ~wd;
            end
            if (mem_req[k]) begin
                n_req++;
                if (req_cyc < 0) begin
                    req_cyc = cyc;
                    chk_eq({tag, ".maddr"},  mem_addr[k],  a);
                    chk_eq({tag, ".mwdata"}, mem_wdata[k], wd);
                    chk_eq({tag, ".mcmd"},   32'(mem_cmd[k]),   32'(c));
                    chk_eq({tag, ".mwidth"}, 32'(mem_width[k]), 32'(w));
                end
            end
            mem_rdata[k] = mrd;
            if (req_cyc >= 0 && mlat >= 0 && cyc == req_cyc + mlat)
                mem_resp[k] = mr;
            else if (req_cyc >= 0 && cyc == req_cyc && mlat != 1)
                mem_resp[k] = SCR1_MEM_RESP_RDY_ER;
            else
                mem_resp[k] = SCR1_MEM_RESP_NOTRDY;
            chk_eq({tag, ".ack_busy"}, 32'(ack[k]), 32'd0);
            if (core_resp[k] != 2'b00) begin
                resp_cyc = cyc;
                got_r    = core_resp[k];
                got_rd   = core_rdata[k];
                break;
            end
        end
        core_req[k] = 1'b0;
        mem_resp[k] = SCR1_MEM_RESP_NOTRDY;
        if (resp_cyc < 0) chk_eq({tag, ".no_resp"}, 32'd0, 32'd1);
        chk_eq({tag, ".req_cyc"}, 32'(req_cyc), (exp_req_cyc < 0) ? 32'hFFFF_FFFF : 32'(exp_req_cyc + d));
        chk_eq({tag, ".n_req"}, 32'(n_req), (exp_req_cyc < 0) ? 32'd0 : 32'd1);
        chk_eq({tag, ".resp_cyc"}, 32'(resp_cyc), 32'(exp_resp_cyc + d));
        chk_eq({tag, ".resp"}, 32'(got_r), 32'(exp_r));
        if (chk_rd) chk_eq({tag, ".rdata"}, got_rd, exp_rd);
        if (rnd && req_cyc >= 2 && req_cyc <= 9) seen_dly[req_cyc - 2] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit bad;
        logic [31:0] v;
        rst_n = 1'b0;
        seen_dly = '0;
        for (int k = 0; k < N; k++) begin
            core_req[k] = 1'b0; core_cmd[k] = SCR1_MEM_CMD_RD; core_width[k] = SCR1_MEM_WIDTH_WORD;
            core_addr[k] = '0; core_wdata[k] = '0; mem_rdata[k] = '0;
            mem_resp[k] = SCR1_MEM_RESP_NOTRDY;
        end
        repeat (3) @(negedge clk);
        chk_eq("rst.resp",   32'(core_resp[0]), 32'd0);
        chk_eq("rst.rdata",  core_rdata[0], 32'd0);
        chk_eq("rst.memreq", 32'(mem_req[0]), 32'd0);
        chk_eq("rst.maddr",  mem_addr[0], 32'd0);
        chk_eq("rst.reqcnt", st_req[0], 32'd0);
        chk_eq("rst.errcnt", st_err[0], 32'd0);
        rst_n = 1'b1;

        txn(0, "rd100", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, 2, 4, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, 1, 0);
        @(negedge clk);
        chk_eq("rd100.reqcnt", st_req[0], 32'd1);
        chk_eq("rd100.rdata_hold", core_rdata[0], 32'hDEADBEEF);
        txn(0, "hw202", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h202, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'h0000_1234, 2, 4, SCR1_MEM_RESP_RDY_OK, 32'h0000_1234, 1, 0);
        txn(0, "hw201", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h201, 32'h55AA,
            1, SCR1_MEM_RESP_RDY_OK, 32'h0, -1, 2, SCR1_MEM_RESP_RDY_ER, 32'h0, 0, 0);
        txn(0, "werr", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h0, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'h0, -1, 2, SCR1_MEM_RESP_RDY_ER, 32'h0, 0, 0);
        @(negedge clk);
        chk_eq("illegal.errcnt", st_err[0], 32'd2);
        chk_eq("illegal.reqcnt", st_req[0], 32'd4);
        txn(0, "tmo", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h104, 32'h0,
            -1, SCR1_MEM_RESP_NOTRDY, 32'hFFFF_FFFF, 2, 11, SCR1_MEM_RESP_RDY_ER, 32'h0, 1, 0);
        txn(0, "post_tmo", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h108, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'h0BADF00D, 2, 4, SCR1_MEM_RESP_RDY_OK, 32'h0BADF00D, 1, 0);
        @(negedge clk);
        chk_eq("tmo.errcnt", st_err[0], 32'd3);
        chk_eq("tmo.reqcnt", st_req[0], 32'd6);

        txn(1, "wr200", SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h12345678,
            2, SCR1_MEM_RESP_RDY_OK, 32'hFFFF_FFFF, 7, 10, SCR1_MEM_RESP_RDY_OK, 32'h0, 1, 0);
        txn(1, "rdb203", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h203, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'h0000_00AB, 7, 9, SCR1_MEM_RESP_RDY_OK, 32'h0000_00AB, 1, 0);

        for (int i = 0; i < 1000; i++) begin
            v = $urandom;
            txn(2, "rnd", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'(i) << 2, 32'h0,
                1, SCR1_MEM_RESP_RDY_OK, v, 2, 4, SCR1_MEM_RESP_RDY_OK, v, 1, 1);
        end
        @(negedge clk);
        chk_eq("rnd.span",   32'(seen_dly), 32'hFF);
        chk_eq("rnd.reqcnt", st_req[2], 32'd1000);
        chk_eq("rnd.errcnt", st_err[2], 32'd0);

        // Drop a transaction sitting in MWAIT with an asynchronous reset.
        @(negedge clk);
        core_req[0] = 1'b1; core_cmd[0] = SCR1_MEM_CMD_RD;
        core_width[0] = SCR1_MEM_WIDTH_WORD; core_addr[0] = 32'h300;
        @(negedge clk);
        core_req[0] = 1'b0;
        @(negedge clk);
        chk_eq("arst.issue", 32'(mem_req[0]), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("arst.memreq", 32'(mem_req[0]), 32'd0);
        chk_eq("arst.resp",   32'(core_resp[0]), 32'd0);
        chk_eq("arst.rdata",  core_rdata[0], 32'd0);
        chk_eq("arst.maddr",  mem_addr[0], 32'd0);
        chk_eq("arst.reqcnt", st_req[0], 32'd0);
        chk_eq("arst.errcnt", st_err[0], 32'd0);
        chk_eq("arst.reqcnt2", st_req[2], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (core_resp[0] != 2'b00 || mem_req[0]) bad = 1'b1;
        end
        chk_eq("arst.silent", 32'(bad), 32'd0);
        txn(0, "post_rst", SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
            1, SCR1_MEM_RESP_RDY_OK, 32'hCAFE_0001, 2, 4, SCR1_MEM_RESP_RDY_OK, 32'hCAFE_0001, 1, 0);
        @(negedge clk);
        chk_eq("post_rst.reqcnt", st_req[0], 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
